// File: rtl/rc4_pkg.sv
// Shared RC4 types and helpers for the KSA stage and the downstream PRGA FSM.
package rc4_pkg;

  localparam int KEY_LEN_DEF   = 3;
  localparam int S_SIZE        = 256;
  localparam int KEY_MAX_BYTES = 16;
  localparam int KEY_W_MAX     = 8 * KEY_MAX_BYTES;

  typedef enum logic [3:0] {
    KSA_IDLE,
    KSA_RD_SI,
    KSA_WAIT_SI,
    KSA_CALC_J,
    KSA_RD_SJ,
    KSA_WAIT_SJ,
    KSA_CAP_SJ,
    KSA_WR_SI,
    KSA_WR_SJ,
    KSA_INC_I,
    KSA_DONE
  } ksa_state_t;

  // Key is right-aligned in the container; byte 0 is the most significant byte of the key.
  function automatic logic [7:0] key_byte(input logic [KEY_W_MAX-1:0] key,
                                          input int unsigned           key_len,
                                          input logic [7:0]            idx);
    int unsigned pos;
    pos = key_len - 32'd1 - (32'(idx) % key_len);
    return 8'(key >> (8 * pos));
  endfunction

endpackage

// File: rtl/ksa_fsm.sv
// RC4 key-scheduling FSM: permutes the identity S-memory in place using the secret key,
// then holds ksa_done until reset.
//
// state    | meaning
// IDLE     | waiting for start (S = identity)
// RD_SI    | present address i
// WAIT_SI  | memory read latency for s[i]
// CALC_J   | capture s[i], update j, present address j
// RD_SJ    | address j registered by memory
// WAIT_SJ  | memory read latency for s[j]
// CAP_SJ   | capture s[j]
// WR_SI    | write s[i] <= old s[j]
// WR_SJ    | write s[j] <= old s[i]
// INC_I    | advance i or finish
// DONE     | sticky completion, port released
import rc4_pkg::*;

module ksa_fsm #(
  parameter int KEY_LEN = KEY_LEN_DEF,
  parameter int RD_WAIT = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [8*KEY_LEN-1:0] secret_key,
  input  logic [7:0]           mem_q,
  output logic [7:0]           mem_addr,
  output logic [7:0]           mem_data,
  output logic                 mem_wren,
  output logic                 ksa_active,
  output logic                 ksa_done
);

  localparam int             WCW       = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
  localparam logic [WCW-1:0] WAIT_INIT = WCW'(RD_WAIT - 1);
  localparam logic [7:0]     I_LAST    = 8'(S_SIZE - 1);

  ksa_state_t     state_q;
  logic [7:0]     i_q, j_q, si_q, sj_q;
  logic [WCW-1:0] wait_q;
  logic [7:0]     mem_addr_q, mem_data_q;
  logic           mem_wren_q, ksa_active_q, ksa_done_q;

  logic [KEY_W_MAX-1:0] key_ext;
  logic [7:0]           kb;
  logic [7:0]           j_d;

  // secret_key is not latched; the caller keeps it stable for the whole run.
  always_comb begin
    key_ext = KEY_W_MAX'(secret_key);
    kb      = key_byte(key_ext, KEY_LEN, i_q);
    j_d     = j_q + mem_q + kb;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= KSA_IDLE;
      i_q          <= 8'd0;
      j_q          <= 8'd0;
      si_q         <= 8'd0;
      sj_q         <= 8'd0;
      wait_q       <= '0;
      mem_addr_q   <= 8'd0;
      mem_data_q   <= 8'd0;
      mem_wren_q   <= 1'b0;
      ksa_active_q <= 1'b0;
      ksa_done_q   <= 1'b0;
    end else begin
      case (state_q)
        KSA_IDLE: begin
          mem_wren_q <= 1'b0;
          if (start) begin
            i_q          <= 8'd0;
            j_q          <= 8'd0;
            mem_addr_q   <= 8'd0;
            ksa_active_q <= 1'b1;
            state_q      <= KSA_RD_SI;
          end
        end
        KSA_RD_SI: begin
          wait_q  <= WAIT_INIT;
          state_q <= KSA_WAIT_SI;
        end
        KSA_WAIT_SI: begin
          if (wait_q == '0) state_q <= KSA_CALC_J;
          else              wait_q  <= wait_q - 1'b1;
        end
        KSA_CALC_J: begin
          si_q       <= mem_q;
          j_q        <= j_d;
          mem_addr_q <= j_d;
          state_q    <= KSA_RD_SJ;
        end
        KSA_RD_SJ: begin
          wait_q  <= WAIT_INIT;
          state_q <= KSA_WAIT_SJ;
        end
        KSA_WAIT_SJ: begin
          if (wait_q == '0) state_q <= KSA_CAP_SJ;
          else              wait_q  <= wait_q - 1'b1;
        end
        KSA_CAP_SJ: begin
          sj_q       <= mem_q;
          mem_addr_q <= i_q;
          mem_data_q <= mem_q;
          mem_wren_q <= 1'b1;
          state_q    <= KSA_WR_SI;
        end
        KSA_WR_SI: begin
          mem_addr_q <= j_q;
          mem_data_q <= si_q;
          state_q    <= KSA_WR_SJ;
        end
        KSA_WR_SJ: begin
          mem_wren_q <= 1'b0;
          state_q    <= KSA_INC_I;
        end
        KSA_INC_I: begin
          if (i_q == I_LAST) begin
            ksa_active_q <= 1'b0;
            ksa_done_q   <= 1'b1;
            state_q      <= KSA_DONE;
          end else begin
            i_q        <= i_q + 8'd1;
            mem_addr_q <= i_q + 8'd1;
            state_q    <= KSA_RD_SI;
          end
        end
        KSA_DONE: begin
          mem_wren_q   <= 1'b0;
          ksa_active_q <= 1'b0;
          ksa_done_q   <= 1'b1;
        end
        default: state_q <= KSA_IDLE;
      endcase
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign mem_wren   = mem_wren_q;
  assign ksa_active = ksa_active_q;
  assign ksa_done   = ksa_done_q;

endmodule

// File: tb/tb_ksa_fsm.sv
// Self-checking bench for ksa_fsm: behavioural S-memory, software KSA model and a write scoreboard.
module tb_ksa_fsm;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [23:0] secret_key;
  logic [7:0]  mem_q, mem_addr, mem_data;
  logic        mem_wren, ksa_active, ksa_done;

  int  n_checks = 0;
  int  n_fail   = 0;
  int  wr_cnt   = 0;
  bit  sb_on    = 1'b0;
  wr_t sb_q[$];

  logic [7:0] smem [256];
  logic [7:0] ld_s [256];
  logic [7:0] ms   [256];
  logic [7:0] addr_r;
  bit         ld_req = 1'b0;

  always #5 clk = ~clk;

  ksa_fsm #(.KEY_LEN(3), .RD_WAIT(1)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .secret_key(secret_key),
    .mem_q     (mem_q),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_wren  (mem_wren),
    .ksa_active(ksa_active),
    .ksa_done  (ksa_done)
  );

  // Registered address, unregistered q.
  always @(posedge clk) begin
    if (ld_req) begin
      for (int k = 0; k < 256; k++) smem[k] <= ld_s[k];
    end else if (mem_wren === 1'b1) begin
      smem[mem_addr] <= mem_data;
    end
    addr_r <= mem_addr;
  end
  assign mem_q = smem[addr_r];

  // Scoreboard monitor: every write cycle pops one expected (addr, data).
  always @(negedge clk) begin
    if (mem_wren === 1'b1) begin
      wr_cnt++;
      if (sb_on) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_extra_write: got addr=%02h data=%02h, required no write", mem_addr, mem_data);
        end else begin
          wr_t e;
          e = sb_q.pop_front();
          if ({mem_addr, mem_data} !== {e.a, e.d}) begin
            n_fail++;
            $display("FAIL sb_write #%0d: got addr=%02h data=%02h, required addr=%02h data=%02h",
                     wr_cnt, mem_addr, mem_data, e.a, e.d);
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    start   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic load_identity();
    for (int k = 0; k < 256; k++) ld_s[k] = 8'(k);
    @(negedge clk);
    ld_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ld_req = 1'b0;
  endtask

  // Software RC4 KSA over ms[], pushing the expected write sequence.
  task automatic model_run(input logic [23:0] key);
    logic [7:0] j, t, kb;
    j = 8'd0;
    for (int i = 0; i < 256; i++) begin
      kb = 8'((key >> (8 * (2 - (i % 3)))) & 24'hFF);
      j  = j + ms[i] + kb;
      sb_q.push_back('{a: 8'(i), d: ms[j]});
      sb_q.push_back('{a: j,     d: ms[i]});
      t     = ms[i];
      ms[i] = ms[j];
      ms[j] = t;
    end
  endtask

  task automatic run_to_done(input bit tog, output int cyc);
    cyc = 0;
    while (ksa_done !== 1'b1 && cyc < 5000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (tog) start = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic test_reset();
    bit bad;
    @(negedge clk);
    reset_n = 1'b0;
    start   = 1'b1;
    secret_key = 24'h000249;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({mem_addr, mem_data} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_addr_data: got %02h/%02h, required 00/00", mem_addr, mem_data);
    end
    n_checks++;
    if ({mem_wren, ksa_active, ksa_done} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got wren/active/done=%b, required 000", {mem_wren, ksa_active, ksa_done});
    end
    start   = 1'b0;
    reset_n = 1'b1;
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (mem_wren !== 1'b0 || ksa_active !== 1'b0 || ksa_done !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL idle_after_reset: outputs left idle with start=0, required wren/active/done=000");
    end
  endtask

  // First three iterations of key 0x000249 against hand-derived writes.
  task automatic test_first_iters();
    int n;
    do_reset();
    load_identity();
    sb_q.delete();
    sb_q.push_back('{a: 8'h00, d: 8'h00});
    sb_q.push_back('{a: 8'h00, d: 8'h00});
    sb_q.push_back('{a: 8'h01, d: 8'h03});
    sb_q.push_back('{a: 8'h03, d: 8'h01});
    sb_q.push_back('{a: 8'h02, d: 8'h4E});
    sb_q.push_back('{a: 8'h4E, d: 8'h02});
    secret_key = 24'h000249;
    wr_cnt = 0;
    sb_on  = 1'b1;
    start  = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ksa_active, ksa_done} !== 2'b10) begin
      n_fail++;
      $display("FAIL active_after_start: got active/done=%b, required 10", {ksa_active, ksa_done});
    end
    n = 0;
    while (wr_cnt < 6 && n < 200) begin
      @(posedge clk);
      n++;
    end
    sb_on = 1'b0;
    n_checks++;
    if (wr_cnt !== 6 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL first_iters_count: got %0d writes (%0d pending), required 6 (0 pending)", wr_cnt, sb_q.size());
    end
    sb_q.delete();
    do_reset();
  endtask

  task automatic test_full_run(input logic [23:0] key, input bit tog, input string name);
    int cyc, errs, w_at_done;
    do_reset();
    load_identity();
    for (int k = 0; k < 256; k++) ms[k] = 8'(k);
    sb_q.delete();
    model_run(key);
    secret_key = key;
    wr_cnt = 0;
    sb_on  = 1'b1;
    start  = 1'b1;
    run_to_done(tog, cyc);
    n_checks++;
    if (cyc !== 2305) begin
      n_fail++;
      $display("FAIL %s latency: got %0d cycles, required 2305", name, cyc);
    end
    n_checks++;
    if (wr_cnt !== 512 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s write_count: got %0d writes (%0d pending), required 512 (0 pending)", name, wr_cnt, sb_q.size());
    end
    errs = 0;
    for (int k = 0; k < 256; k++) if (smem[k] !== ms[k]) errs++;
    n_checks++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL %s final_s: %0d bytes differ from model, required 0", name, errs);
    end
    if (tog) begin
      w_at_done = wr_cnt;
      errs = 0;
      repeat (40) begin
        @(negedge clk);
        start = ~start;
        if (ksa_done !== 1'b1 || ksa_active !== 1'b0) errs++;
      end
      n_checks++;
      if (errs != 0 || wr_cnt != w_at_done) begin
        n_fail++;
        $display("FAIL %s sticky_done: %0d bad cycles, %0d extra writes, required 0 and 0",
                 name, errs, wr_cnt - w_at_done);
      end
      errs = 0;
      for (int k = 0; k < 256; k++) if (smem[k] !== ms[k]) errs++;
      n_checks++;
      if (errs != 0) begin
        n_fail++;
        $display("FAIL %s s_after_done: %0d bytes changed, required 0", name, errs);
      end
    end
    sb_on = 1'b0;
    start = 1'b0;
    sb_q.delete();
  endtask

  task automatic test_reset_mid();
    int w, n, cyc, errs;
    do_reset();
    load_identity();
    sb_q.delete();
    secret_key = 24'h000249;
    sb_on = 1'b0;
    start = 1'b1;
    w = 0;
    n = 0;
    while (w < 201 && n < 2000) begin
      @(negedge clk);
      n++;
      if (mem_wren === 1'b1) w++;
    end
    n_checks++;
    if (mem_addr !== 8'd100 || mem_wren !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_wr_si_i100: got addr=%02h wren=%b, required addr=64 wren=1", mem_addr, mem_wren);
    end
    reset_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({mem_addr, mem_data, mem_wren, ksa_active, ksa_done} !== 19'h0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got addr=%02h data=%02h wren/active/done=%b, required all 0",
               mem_addr, mem_data, {mem_wren, ksa_active, ksa_done});
    end
    start   = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 256; k++) ms[k] = smem[k];
    model_run(24'h000249);
    wr_cnt = 0;
    sb_on  = 1'b1;
    start  = 1'b1;
    run_to_done(1'b0, cyc);
    n_checks++;
    if (cyc !== 2305 || wr_cnt !== 512) begin
      n_fail++;
      $display("FAIL restart_run: got %0d cycles/%0d writes, required 2305/512", cyc, wr_cnt);
    end
    errs = 0;
    for (int k = 0; k < 256; k++) if (smem[k] !== ms[k]) errs++;
    n_checks++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL restart_final_s: %0d bytes differ from model, required 0", errs);
    end
    sb_on = 1'b0;
    start = 1'b0;
    sb_q.delete();
  endtask

  // Zero key on identity S: iteration 0 has j == i == 0.
  task automatic test_i_eq_j();
    int n;
    do_reset();
    load_identity();
    sb_q.delete();
    sb_q.push_back('{a: 8'h00, d: 8'h00});
    sb_q.push_back('{a: 8'h00, d: 8'h00});
    secret_key = 24'h000000;
    wr_cnt = 0;
    sb_on  = 1'b1;
    start  = 1'b1;
    n = 0;
    while (wr_cnt < 2 && n < 100) begin
      @(posedge clk);
      n++;
    end
    sb_on = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (wr_cnt !== 2 || smem[0] !== 8'h00) begin
      n_fail++;
      $display("FAIL i_eq_j: got %0d writes, s[0]=%02h, required 2 writes, s[0]=00", wr_cnt, smem[0]);
    end
    sb_q.delete();
    test_full_run(24'h000000, 1'b0, "key000000");
  endtask

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    secret_key = 24'h0;
    test_reset();
    test_first_iters();
    test_full_run(24'h000249, 1'b0, "key000249");
    test_full_run(24'hFFFFFF, 1'b1, "keyFFFFFF_toggle");
    test_reset_mid();
    test_i_eq_j();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ksa_fsm.md
Name: ksa_fsm

Overview:
- RC4 key-scheduling stage (KSA) of the RC4 decrypt datapath.
- Runs after the S-memory init stage has written s[i]=i. Permutes S in place using the 24-bit secret key.
- Then raises ksa_done, which is the fsm2_done input of the downstream PRGA/decrypt FSM.
- Owns the shared S-memory port (address/data/wren, q) while active; the top-level mux selects this block's port whenever ksa_active=1.

Parameters:
- KEY_LEN, 3, key length in bytes; key byte index = i mod KEY_LEN.
- RD_WAIT, 1, wait cycles between presenting mem_addr and sampling mem_q. 1 matches the registered-address, unregistered-q s_memory.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- start  in  1  level from init stage (S = identity complete); sampled in IDLE only
- secret_key  in  8*KEY_LEN  key; byte0 = secret_key[8*KEY_LEN-1 -: 8] (MSB first)
- mem_q  in  8  S-memory read data (out_mem)
- mem_addr  out  8  S-memory address
- mem_data  out  8  S-memory write data
- mem_wren  out  1  S-memory write enable
- ksa_active  out  1  high in every state except IDLE and DONE
- ksa_done  out  1  high only in DONE (feeds fsm2_done)

Behaviour:
- Reset (reset_n=0 at posedge clk):
  - state=IDLE, i=0, j=0, si_q=0, sj_q=0.
  - mem_addr=0, mem_data=0, mem_wren=0, ksa_active=0, ksa_done=0.
  - Reset has priority in every state, including mid-swap. A write in flight is simply dropped; the partially permuted S is not repaired.
- Algorithm:
  - For i=0..255: j = j + s[i] + key[i mod KEY_LEN] (mod 256); then swap s[i] and s[j].
  - All arithmetic is 8-bit wrapping. i is a 9-bit counter, or 8-bit plus a last flag, so i=255 terminates cleanly.
- States, one cycle each unless noted:
  - IDLE: mem_wren=0. If start=1, go to RD_SI with i=0, j=0.
  - RD_SI: mem_addr=i. Go to WAIT_SI.
  - WAIT_SI: hold mem_addr=i for RD_WAIT cycles.
  - CALC_J: si_q<=mem_q; j<=j+mem_q+key_byte(i). Go to RD_SJ.
  - RD_SJ: mem_addr=j (the new j). Go to WAIT_SJ.
  - WAIT_SJ: hold for RD_WAIT cycles.
  - CAP_SJ: sj_q<=mem_q.
  - WR_SI: mem_addr=i, mem_data=sj_q, mem_wren=1.
  - WR_SJ: mem_addr=j, mem_data=si_q, mem_wren=1.
  - INC_I: mem_wren=0. If i==255 go to DONE, else i<=i+1 and go to RD_SI.
  - DONE: ksa_done=1, ksa_active=0, mem_wren=0. Sticky until reset; start is ignored.
- mem_wren is high only in WR_SI and WR_SJ: exactly 512 write cycles per run.
- Latency with RD_WAIT=1:
  - 9 cycles per iteration; ksa_done rises 2305 cycles after the IDLE cycle that sampled start=1.
  - General form: 256*(7+2*RD_WAIT)+1 cycles.
- Boundary cases:
  - i==j: both reads return the same value and both writes write it back. The cell is unchanged, which is correct.
  - j wraps modulo 256 silently.
  - start toggling while active is ignored.
  - secret_key must be stable from start until done. It is not latched; it is read combinationally per byte.
- Outputs are registered. No combinational path from start or mem_q to any output.

Decomposition:
- Package rc4_pkg:
  - ksa_state_t enum.
  - KEY_LEN_DEF=3, S_SIZE=256.
  - key_byte(key, idx) function; the downstream PRGA FSM reuses it.
- No sub-module. The swap sequence is short and inline. A reusable swap unit is not justified at this size.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with start=1 → all outputs 0, state IDLE. Release with start=0 → stays IDLE, mem_wren never high.
- Key 0x000249, behavioural S memory preloaded with identity:
  - i=0 rewrites s[0]=0 (j=0).
  - i=1 gives j=3, writes s[1]=3 then s[3]=1.
  - i=2 gives j=0x4E, writes s[2]=0x4E then s[0x4E]=2.
  - Check each write cycle's mem_addr and mem_data.
- Full run, key 0x000249 and key 0xFFFFFF: final 256-byte S matches a software RC4 KSA model. ksa_done rises exactly 2305 cycles after start is sampled, and exactly 512 write cycles are seen.
- Toggle start high/low during the run and at DONE → no restart, ksa_done stays 1, final S unchanged.
- Reset asserted during WR_SI at i=100 → next cycle all outputs 0, IDLE. Reassert start → run restarts from i=0, j=0.
- i==j case, key 0x000000 with identity S: iteration i=0 has j=0 → two writes of value 0 to address 0, no corruption.
